// File: rtl/ulpi_link_ctrl.sv
// Link-side ULPI bus sequencer: arbitrates PHY register writes/reads and USB
// packet transmit on the shared 8-bit bus, and captures RX CMD / RX data.
module ulpi_link_ctrl #(
    parameter int REG_PRIO    = 1,
    parameter int NXT_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dir,
    input  logic       nxt,
    output logic       stp,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_oe,
    input  logic       reg_req,
    input  logic       reg_we,
    input  logic [5:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic       reg_ack,
    output logic       reg_err,
    output logic [7:0] reg_rdata,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_err,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rxcmd_valid,
    output logic [7:0] rxcmd
);

    typedef enum logic [3:0] {
        IDLE,
        TX_CMD,
        TX_DATA,
        TX_STP,
        TX_FLUSH,
        RW_CMD,
        RW_DATA,
        RW_STP,
        RR_CMD,
        RR_TURN,
        RR_DATA,
        RR_END
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            dir_q;
    logic            bus_own;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            waiting;
    logic            reg_go;
    logic            ack_set;
    logic            err_set;
    logic            txerr_set;
    logic            rd_cap;
    logic            rx_samp;
    logic            cmd_samp;

    assign bus_own = !dir && !dir_q;
    assign data_oe = !rst && bus_own;
    assign to_hit  = (to_cnt == TO_W'(NXT_TIMEOUT - 1));

    // An outstanding reg_ack blocks re-arbitration so the requester has a
    // cycle to drop reg_req before the same access would be started again.
    assign reg_go  = reg_req && !reg_ack;

    // Turnaround data during a register read is the read result, not an RX CMD.
    assign rx_samp  = dir && dir_q && nxt;
    assign cmd_samp = dir && dir_q && !nxt && (state != RR_DATA);

    always_comb begin
        state_nx  = state;
        data_o    = '0;
        stp       = 1'b0;
        tx_ready  = 1'b0;
        ack_set   = 1'b0;
        err_set   = 1'b0;
        txerr_set = 1'b0;
        rd_cap    = 1'b0;
        waiting   = 1'b0;
        case (state)
            IDLE: begin
                if (bus_own) begin
                    if (reg_go && (REG_PRIO != 0 || !tx_valid)) begin
                        state_nx = reg_we ? RW_CMD : RR_CMD;
                    end else if (tx_valid) begin
                        state_nx = TX_CMD;
                    end
                end
            end
            TX_CMD: begin
                data_o = {4'h4, tx_data[3:0]};
                if (dir) begin
                    state_nx = IDLE;
                end else if (nxt) begin
                    tx_ready = 1'b1;
                    state_nx = tx_last ? TX_STP : TX_DATA;
                end else begin
                    waiting = 1'b1;
                    if (to_hit) begin
                        txerr_set = 1'b1;
                        state_nx  = TX_FLUSH;
                    end
                end
            end
            TX_DATA: begin
                data_o = tx_data;
                if (dir) begin
                    txerr_set = 1'b1;
                    state_nx  = TX_FLUSH;
                end else if (nxt) begin
                    if (tx_valid) begin
                        tx_ready = 1'b1;
                        if (tx_last) state_nx = TX_STP;
                    end else begin
                        stp       = 1'b1;
                        data_o    = 8'hFF;
                        txerr_set = 1'b1;
                        state_nx  = TX_FLUSH;
                    end
                end
            end
            TX_STP: begin
                stp      = 1'b1;
                state_nx = IDLE;
            end
            TX_FLUSH: begin
                tx_ready = tx_valid;
                if (tx_valid && tx_last) state_nx = IDLE;
            end
            RW_CMD: begin
                data_o = {2'b10, reg_addr};
                if (dir) begin
                    state_nx = IDLE;
                end else if (nxt) begin
                    state_nx = RW_DATA;
                end else begin
                    waiting = 1'b1;
                    if (to_hit) begin
                        ack_set  = 1'b1;
                        err_set  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            RW_DATA: begin
                data_o = reg_wdata;
                // Leaving through IDLE retries from RW_CMD once the bus returns.
                if (dir) state_nx = IDLE;
                else if (nxt) state_nx = RW_STP;
            end
            RW_STP: begin
                stp      = 1'b1;
                ack_set  = 1'b1;
                state_nx = IDLE;
            end
            RR_CMD: begin
                data_o = {2'b11, reg_addr};
                if (dir) begin
                    state_nx = IDLE;
                end else if (nxt) begin
                    state_nx = RR_TURN;
                end else begin
                    waiting = 1'b1;
                    if (to_hit) begin
                        ack_set  = 1'b1;
                        err_set  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            RR_TURN: begin
                if (dir) state_nx = nxt ? IDLE : RR_DATA;
            end
            RR_DATA: begin
                rd_cap   = 1'b1;
                state_nx = RR_END;
            end
            RR_END: begin
                if (!dir) begin
                    ack_set  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dir_q       <= 1'b0;
            to_cnt      <= '0;
            reg_ack     <= 1'b0;
            reg_err     <= 1'b0;
            reg_rdata   <= '0;
            tx_err      <= 1'b0;
            rx_active   <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rxcmd_valid <= 1'b0;
            rxcmd       <= '0;
        end else begin
            state   <= state_nx;
            dir_q   <= dir;
            reg_ack <= ack_set;
            reg_err <= err_set;
            tx_err  <= txerr_set;

            if (state_nx != state) to_cnt <= '0;
            else if (waiting) to_cnt <= to_cnt + TO_W'(1);

            if (rd_cap) reg_rdata <= data_i;

            rx_valid <= rx_samp;
            if (rx_samp) rx_data <= data_i;

            rxcmd_valid <= cmd_samp;
            if (cmd_samp) rxcmd <= data_i;

            if (!dir && dir_q) rx_active <= 1'b0;
            else if (cmd_samp && !data_i[4]) rx_active <= 1'b0;
            else if (dir && !dir_q && nxt) rx_active <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// Directed bench for ulpi_link_ctrl: a hand-driven PHY with scoreboards for
// accepted bus bytes, register completions and RX CMD bytes.
module tb_ulpi_link_ctrl;

    logic       clk;
    logic       rst;
    logic       dir;
    logic       nxt;
    logic       stp;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       data_oe;
    logic       reg_req;
    logic       reg_we;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_ack;
    logic       reg_err;
    logic [7:0] reg_rdata;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_err;
    logic       rx_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rxcmd_valid;
    logic [7:0] rxcmd;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_bus[$];
    logic [8:0] exp_ack[$];
    logic [7:0] exp_rxcmd[$];
    logic [7:0] model_rdata;
    logic [7:0] beats[3];
    int         nready;
    int         cmd_cycles;
    logic       seen;

    ulpi_link_ctrl #(
        .REG_PRIO(1),
        .NXT_TIMEOUT(64),
        .TO_W(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dir(dir),
        .nxt(nxt),
        .stp(stp),
        .data_i(data_i),
        .data_o(data_o),
        .data_oe(data_oe),
        .reg_req(reg_req),
        .reg_we(reg_we),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_ack(reg_ack),
        .reg_err(reg_err),
        .reg_rdata(reg_rdata),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_last(tx_last),
        .tx_ready(tx_ready),
        .tx_err(tx_err),
        .rx_active(rx_active),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rxcmd_valid(rxcmd_valid),
        .rxcmd(rxcmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // PHY accepts the byte currently on the bus (nxt high this cycle).
    task automatic accept(input string tag);
        logic [7:0] e;
        check({tag, "_oe"}, 32'(data_oe), 32'd1);
        check({tag, "_queued"}, 32'(exp_bus.size() != 0), 32'd1);
        if (exp_bus.size() != 0) begin
            e = exp_bus.pop_front();
            check(tag, 32'(data_o), 32'(e));
        end
    endtask

    task automatic pop_ack(input string tag);
        logic [8:0] e;
        check({tag, "_queued"}, 32'(exp_ack.size() != 0), 32'd1);
        if (exp_ack.size() != 0) begin
            e = exp_ack.pop_front();
            check(tag, 32'({reg_err, reg_rdata}), 32'(e));
        end
    endtask

    task automatic wait_ack(input string tag, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            cyc();
            settle();
            if (reg_ack) got = 1'b1;
        end
        check({tag, "_seen"}, 32'(got), 32'd1);
        if (got) pop_ack(tag);
        reg_req = 1'b0;
    endtask

    task automatic chk_rxcmd(input string tag);
        logic [7:0] e;
        check({tag, "_valid"}, 32'(rxcmd_valid), 32'd1);
        check({tag, "_queued"}, 32'(exp_rxcmd.size() != 0), 32'd1);
        if (exp_rxcmd.size() != 0) begin
            e = exp_rxcmd.pop_front();
            check(tag, 32'(rxcmd), 32'(e));
        end
    endtask

    initial begin
        rst = 1'b1; dir = 1'b0; nxt = 1'b0; data_i = '0;
        reg_req = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
        model_rdata = 8'h00;
        beats[0] = 8'hC3; beats[1] = 8'hA1; beats[2] = 8'hB2;

        // reset state
        repeat (3) cyc();
        settle();
        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_stp", 32'(stp), 32'd0);
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_pulses", 32'({reg_ack, reg_err, tx_ready, tx_err, rx_valid, rxcmd_valid, rx_active}), 32'd0);
        check("rst_rdata", 32'(reg_rdata), 32'h00);
        check("rst_rxcmd", 32'(rxcmd), 32'h00);
        rst = 1'b0;
        cyc(); settle();
        check("idle_oe", 32'(data_oe), 32'd1);
        check("idle_data", 32'(data_o), 32'h00);

        // register write 0x0A <= 0x55
        reg_we = 1'b1; reg_addr = 6'h0A; reg_wdata = 8'h55; reg_req = 1'b1;
        exp_bus.push_back(8'h8A); exp_bus.push_back(8'h55);
        exp_ack.push_back({1'b0, model_rdata});
        cyc(); settle(); check("wr_cmd_hold", 32'(data_o), 32'h8A);
        cyc(); nxt = 1'b1; settle(); accept("wr_cmd");
        cyc(); nxt = 1'b0; settle(); check("wr_data_hold", 32'(data_o), 32'h55);
        cyc(); nxt = 1'b1; settle(); accept("wr_data");
        cyc(); nxt = 1'b0; settle();
        check("wr_stp", 32'(stp), 32'd1);
        check("wr_stp_data", 32'(data_o), 32'h00);
        check("wr_early_ack", 32'(reg_ack), 32'd0);
        wait_ack("wr_ack", 4);
        check("wr_stp_off", 32'(stp), 32'd0);
        cyc(); settle(); check("wr_ack_pulse", 32'(reg_ack), 32'd0);

        // register read 0x04 -> 0x3C
        reg_we = 1'b0; reg_addr = 6'h04; reg_req = 1'b1; model_rdata = 8'h3C;
        exp_bus.push_back(8'hC4); exp_ack.push_back({1'b0, 8'h3C});
        cyc(); settle(); check("rd_cmd_hold", 32'(data_o), 32'hC4);
        cyc(); nxt = 1'b1; settle(); accept("rd_cmd");
        cyc(); nxt = 1'b0; dir = 1'b1; settle(); check("rd_turn_oe", 32'(data_oe), 32'd0);
        cyc(); data_i = 8'h3C; settle(); check("rd_data_oe", 32'(data_oe), 32'd0);
        cyc(); dir = 1'b0; data_i = 8'h00; settle();
        check("rd_end_oe", 32'(data_oe), 32'd0);
        check("rd_early_ack", 32'(reg_ack), 32'd0);
        check("rd_not_rxcmd", 32'(rxcmd_valid), 32'd0);
        wait_ack("rd_ack", 4);
        check("rd_rxcmd_untouched", 32'(rxcmd), 32'h00);

        // TX packet: PID 3 + 2 bytes, nxt always high
        tx_data = beats[0]; tx_last = 1'b0; tx_valid = 1'b1; nxt = 1'b1;
        exp_bus.push_back(8'h43); exp_bus.push_back(8'hA1); exp_bus.push_back(8'hB2);
        nready = 0;
        settle(); check("tx_idle_ready", 32'(tx_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            tx_data = beats[i]; tx_last = (i == 2);
            settle();
            accept("tx_beat");
            if (tx_ready) nready++;
        end
        cyc(); tx_valid = 1'b0; tx_last = 1'b0; nxt = 1'b0; settle();
        check("tx_stp", 32'(stp), 32'd1);
        check("tx_stp_data", 32'(data_o), 32'h00);
        check("tx_stp_ready", 32'(tx_ready), 32'd0);
        check("tx_ready_beats", 32'(nready), 32'd3);
        cyc(); settle();
        check("tx_stp_off", 32'(stp), 32'd0);
        check("tx_no_err", 32'(tx_err), 32'd0);

        // TX underrun after PID
        tx_data = 8'hE1; tx_valid = 1'b1; tx_last = 1'b0; nxt = 1'b1;
        exp_bus.push_back(8'h41);
        cyc(); settle(); accept("ur_pid"); check("ur_pid_ready", 32'(tx_ready), 32'd1);
        cyc(); tx_valid = 1'b0; settle();
        check("ur_stp", 32'(stp), 32'd1);
        check("ur_ff", 32'(data_o), 32'hFF);
        check("ur_ready", 32'(tx_ready), 32'd0);
        cyc(); nxt = 1'b0; tx_valid = 1'b1; tx_data = 8'h11; settle();
        check("ur_err", 32'(tx_err), 32'd1);
        check("ur_flush0", 32'(tx_ready), 32'd1);
        check("ur_flush_stp", 32'(stp), 32'd0);
        cyc(); tx_data = 8'h22; settle();
        check("ur_err_pulse", 32'(tx_err), 32'd0);
        check("ur_flush1", 32'(tx_ready), 32'd1);
        cyc(); tx_data = 8'h33; tx_last = 1'b1; settle();
        check("ur_flush2", 32'(tx_ready), 32'd1);
        cyc(); tx_valid = 1'b0; tx_last = 1'b0; settle();
        check("ur_idle_data", 32'(data_o), 32'h00);
        check("ur_idle_ready", 32'(tx_ready), 32'd0);

        // PHY abort of a write command with RX CMD 0x1D, then retry
        reg_we = 1'b1; reg_addr = 6'h15; reg_wdata = 8'h66; reg_req = 1'b1;
        exp_bus.push_back(8'h95); exp_bus.push_back(8'h66);
        exp_ack.push_back({1'b0, model_rdata});
        cyc(); settle(); check("ab_cmd", 32'(data_o), 32'h95);
        cyc(); dir = 1'b1; settle(); check("ab_turn1_oe", 32'(data_oe), 32'd0);
        cyc(); data_i = 8'h1D; exp_rxcmd.push_back(8'h1D); settle();
        check("ab_rx_oe", 32'(data_oe), 32'd0);
        cyc(); dir = 1'b0; data_i = 8'h00; settle();
        check("ab_turn2_oe", 32'(data_oe), 32'd0);
        chk_rxcmd("ab_rxcmd");
        check("ab_no_ack", 32'(reg_ack), 32'd0);
        check("ab_rx_active", 32'(rx_active), 32'd0);
        cyc(); settle();
        check("ab_idle_oe", 32'(data_oe), 32'd1);
        check("ab_rxcmd_pulse", 32'(rxcmd_valid), 32'd0);
        check("ab_rxcmd_hold", 32'(rxcmd), 32'h1D);
        cyc(); nxt = 1'b1; settle(); accept("ab_retry_cmd");
        cyc(); settle(); accept("ab_retry_data");
        cyc(); nxt = 1'b0; settle(); check("ab_stp", 32'(stp), 32'd1);
        check("ab_no_txerr", 32'(tx_err), 32'd0);
        wait_ack("ab_ack", 4);

        // Received packet: rx_active, rx data, RX CMD with RxActive low
        cyc(); dir = 1'b1; nxt = 1'b1; settle(); check("rx_rise_oe", 32'(data_oe), 32'd0);
        cyc(); data_i = 8'hA5; settle(); check("rx_active_set", 32'(rx_active), 32'd1);
        cyc(); nxt = 1'b0; data_i = 8'h0E; exp_rxcmd.push_back(8'h0E); settle();
        check("rx_valid", 32'(rx_valid), 32'd1);
        check("rx_data", 32'(rx_data), 32'hA5);
        cyc(); dir = 1'b0; data_i = 8'h00; settle();
        chk_rxcmd("rx_rxcmd");
        check("rx_active_clr", 32'(rx_active), 32'd0);
        check("rx_valid_off", 32'(rx_valid), 32'd0);
        cyc(); settle();

        // Simultaneous requests, register first, nxt never comes -> timeout
        reg_we = 1'b1; reg_addr = 6'h21; reg_wdata = 8'h77; reg_req = 1'b1;
        tx_valid = 1'b1; tx_data = 8'hD2; tx_last = 1'b1; nxt = 1'b0;
        exp_bus.push_back(8'h42); exp_ack.push_back({1'b1, model_rdata});
        cmd_cycles = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cyc(); settle();
            if (reg_ack) seen = 1'b1;
            else if (data_oe && data_o == 8'hA1) cmd_cycles++;
        end
        check("to_seen", 32'(seen), 32'd1);
        check("to_cmd_cycles", 32'(cmd_cycles), 32'd64);
        if (seen) pop_ack("to_ack");
        reg_req = 1'b0;
        cyc(); settle();
        check("to_tx_cmd", 32'(data_o), 32'h42);
        check("to_tx_wait", 32'(tx_ready), 32'd0);
        check("to_ack_pulse", 32'(reg_ack), 32'd0);
        cyc(); nxt = 1'b1; settle(); accept("to_tx_pid");
        check("to_tx_ready", 32'(tx_ready), 32'd1);
        cyc(); tx_valid = 1'b0; tx_last = 1'b0; nxt = 1'b0; settle();
        check("to_tx_stp", 32'(stp), 32'd1);
        cyc(); settle();

        check("end_bus_queue", 32'(exp_bus.size()), 32'd0);
        check("end_ack_queue", 32'(exp_ack.size()), 32'd0);
        check("end_rxcmd_queue", 32'(exp_rxcmd.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ulpi_link_ctrl.md
Name: ulpi_link_ctrl

Overview:
Link-side ULPI bus controller that sequences the 8-bit ULPI data bus between three users: PHY register writes, PHY register reads, and outgoing USB packet transmission.
- Tracks bus direction and turnaround, and captures RX CMD bytes and received packet data.
- Sits between the ulpi_if link modport and the USB protocol engine.
- The tri-state data bus is split into data_i/data_o/data_oe; the top level does the tri-state.

Parameters:
REG_PRIO, 1, 1: pending register access wins over pending TX at IDLE; 0: TX wins.
NXT_TIMEOUT, 64, max cycles waiting for nxt on a TX CMD before the access is abandoned with an error.
TO_W, 7, width of the timeout counter; must hold NXT_TIMEOUT.

Ports:
clk  input  1  ULPI 60 MHz clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
dir  input  1  ULPI dir from PHY.
nxt  input  1  ULPI nxt from PHY.
stp  output  1  ULPI stp to PHY.
data_i  input  8  ULPI data as sampled.
data_o  output  8  ULPI data driven by link.
data_oe  output  1  link drives data when 1.
reg_req  input  1  register access request; held until reg_ack.
reg_we  input  1  1 = write, 0 = read; stable while reg_req.
reg_addr  input  6  PHY register address.
reg_wdata  input  8  write data.
reg_ack  output  1  one-cycle pulse: access complete.
reg_err  output  1  one-cycle pulse with reg_ack: access failed (timeout).
reg_rdata  output  8  read result; valid from reg_ack until the next access.
tx_valid  input  1  TX byte available; first beat of a packet is the PID.
tx_data  input  8  TX byte.
tx_last  input  1  final beat of the packet.
tx_ready  output  1  beat consumed this cycle.
tx_err  output  1  one-cycle pulse: packet aborted (PHY abort or underrun).
rx_active  output  1  PHY owns the bus and is delivering packet data.
rx_valid  output  1  rx_data valid this cycle.
rx_data  output  8  received byte.
rxcmd_valid  output  1  one-cycle pulse: new RX CMD byte.
rxcmd  output  8  last RX CMD byte; holds value.

Behaviour:
- Reset values: stp 0, data_o 0x00, data_oe 0, reg_ack/reg_err/tx_ready/tx_err/rx_valid/rxcmd_valid/rx_active 0, reg_rdata 0x00, rxcmd 0x00. State returns to IDLE and the timeout counter is cleared. Reset mid-transfer drops the access with no ack.
- dir_q is the registered dir. turnaround = dir ^ dir_q. data_oe = !dir & !dir_q, so the link never drives during a turnaround cycle.
- RX sampling (dir & dir_q): nxt=1 gives rx_valid=1 and rx_data=data_i. nxt=0 updates rxcmd=data_i and pulses rxcmd_valid.
- rx_active is set when dir rises with nxt=1, and cleared when dir falls or an RX CMD reports RxActive (bit 4) = 0.
- TX CMD encodings:
  - Transmit: 0x40|PID[3:0].
  - Register write: 0x80|addr.
  - Register read: 0xC0|addr.
- States: IDLE, TX_CMD, TX_DATA, TX_STP, TX_FLUSH, RW_CMD, RW_DATA, RW_STP, RR_CMD, RR_TURN, RR_DATA, RR_END.
- IDLE: acts only when data_oe=1 (bus owned, no turnaround). Arbitration follows REG_PRIO. Otherwise the machine stays idle with data_o=0x00.
- TX_CMD: drive 0x40|tx_data[3:0]. On nxt: tx_ready=1 (PID consumed). If tx_last, go to TX_STP, else go to TX_DATA.
- TX_DATA: drive tx_data; tx_ready=nxt&tx_valid.
  - Consumed tx_last: go to TX_STP.
  - tx_valid=0 while nxt=1 (underrun): drive stp=1 with data 0xFF, pulse tx_err, go to TX_FLUSH.
- TX_STP: stp=1, data 0x00, one cycle, then IDLE.
- TX_FLUSH: tx_ready=1 on every valid beat, discarding it, until tx_last is consumed; then IDLE.
- Write sequence:
  - RW_CMD: drive 0x80|addr until nxt.
  - RW_DATA: drive reg_wdata until nxt.
  - RW_STP: stp=1 for one cycle, reg_ack pulse, then IDLE.
- Read sequence:
  - RR_CMD: drive 0xC0|addr until nxt.
  - RR_TURN: the cycle dir rises; no drive.
  - RR_DATA: capture data_i into reg_rdata.
  - RR_END: wait for dir low, pulse reg_ack, then IDLE.
- PHY abort: dir rising in any *_CMD state before nxt cancels the command. Return to IDLE with the request still pending, so it is retried with no ack and no tx_err.
- dir rising in TX_DATA: tx_err pulse, go to TX_FLUSH.
- dir rising in RW_DATA: retry from RW_CMD after dir falls.
- In RR_TURN, if nxt=1 with dir the PHY is starting a packet (read aborted): retry after dir falls.
- Timeout: the counter increments each cycle a *_CMD state waits for nxt.
  - Reaching NXT_TIMEOUT on a register access: reg_ack+reg_err, IDLE.
  - Reaching NXT_TIMEOUT on TX: tx_err, go to TX_FLUSH.
  - The counter clears on every state change.

Test Plan:
- Register write addr 0x0A, data 0x55; PHY asserts nxt one cycle after each byte. Expect data_o 0x8A then 0x55, stp for one cycle, reg_ack one cycle later, reg_err=0.
- Register read addr 0x04; PHY returns 0x3C after turnaround. Expect data_o 0xC4, data_oe=0 from the dir-rise cycle on, reg_rdata=0x3C with reg_ack after dir falls.
- TX packet PID 0x3 + 2 bytes with nxt always 1. Expect data_o 0x43, both data bytes, 3 tx_ready beats, then stp=1 with data 0x00.
- TX underrun: tx_valid drops after the PID while nxt=1. Expect stp=1, data_o=0xFF, tx_err pulse, remaining beats flushed through tx_last.
- dir rises during RW_CMD, PHY sends RX CMD 0x1D then drops dir. Expect rxcmd=0x1D with a one-cycle rxcmd_valid, no drive in either turnaround cycle, write retried and acked.
- reg_req and tx_valid asserted together with REG_PRIO=1, and nxt held 0. Expect the register command first; after 64 cycles reg_ack+reg_err; then 0x40|PID is driven.
